// File: rtl/div_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | div_pkg : shared types and constants for the divider sequencer   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package div_pkg;

    localparam int OPERAND_W         = 32;
    localparam int RESULT_W          = 64;
    localparam int CNT_W             = 4;
    localparam int SETTLE_CYCLES_DEF = 2;

    localparam logic [RESULT_W-1:0] DIV0_QUOTIENT = {RESULT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | div_sequencer : holds operands on an external combinational      |
// | divider, captures its result, and short-circuits divide-by-zero  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module div_sequencer
    import div_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_dividend,
    input  logic [OPERAND_W-1:0] in_divisor,
    output logic [OPERAND_W-1:0] div_dividend,
    output logic [OPERAND_W-1:0] div_divisor,
    input  logic [RESULT_W-1:0]  div_quotient,
    input  logic [RESULT_W-1:0]  div_remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RESULT_W-1:0]  out_quotient,
    output logic [RESULT_W-1:0]  out_remainder,
    output logic                 out_error,
    output logic [7:0]           err_count
);

    localparam logic [CNT_W-1:0] c_settle = CNT_W'(SETTLE_CYCLES);

    state_e                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_up;
    logic [OPERAND_W-1:0]   r_dividend;
    logic [OPERAND_W-1:0]   r_divisor;
    logic [RESULT_W-1:0]    r_quot;
    logic [RESULT_W-1:0]    r_rem;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_div0;

    // r_up keeps in_ready low until the first edge after reset release
    assign in_ready  = r_up && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_div0    = (in_divisor == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_up       <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_up <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dividend <= in_dividend;
                        r_divisor  <= in_divisor;
                        if (w_div0) begin
                            r_quot  <= DIV0_QUOTIENT;
                            r_rem   <= {{(RESULT_W-OPERAND_W){1'b0}}, in_dividend};
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= c_settle;
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_quot  <= div_quotient;
                        r_rem   <= div_remainder;
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign out_quotient  = r_quot;
    assign out_remainder = r_rem;
    assign out_error     = r_err;

    sat_counter #(
        .WIDTH (8)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_accept && w_div0),
        .o_count (err_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_div_sequencer : directed self-checking bench for div_sequencer|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_div_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [63:0] div_quotient;
    logic [63:0] div_remainder;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_quotient;
    logic [63:0] out_remainder;
    logic        out_error;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;

    // Stand-in for the external divider; a junk value on zero divisor must never be captured
    assign div_quotient  = (div_divisor == 32'd0) ? 64'h0000_DEAD_0000_BEEF
                                                 : {32'h0, div_dividend / div_divisor};
    assign div_remainder = (div_divisor == 32'd0) ? 64'h0000_0BAD_0000_0BAD
                                                 : {32'h0, div_dividend % div_divisor};

    div_sequencer #(
        .SETTLE_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_error     (out_error),
        .err_count     (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(n), 64'(exp_lat));
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk(tag, {63'h0, out_valid}, 64'd0);
    endtask

    initial begin
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  {63'h0, in_ready},  64'd0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_quot",      out_quotient,       64'd0);
        chk("rst_rem",       out_remainder,      64'd0);
        chk("rst_err",       {63'h0, out_error}, 64'd0);
        chk("rst_errcnt",    {56'h0, err_count}, 64'd0);
        chk("rst_div_a",     {32'h0, div_dividend}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_lo", {63'h0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_hi", {63'h0, in_ready}, 64'd1);

        // 100 / 7
        accept(32'd100, 32'd7);
        chk("s_in_ready",  {63'h0, in_ready}, 64'd0);
        chk("s_div_a",     {32'h0, div_dividend}, 64'd100);
        chk("s_div_b",     {32'h0, div_divisor},  64'd7);
        wait_valid("lat_100_7", 2);
        chk("q_100_7",     out_quotient,  64'd14);
        chk("r_100_7",     out_remainder, 64'd2);
        chk("e_100_7",     {63'h0, out_error}, 64'd0);
        drain("drain_100_7");

        // 55 / 0
        accept(32'd55, 32'd0);
        wait_valid("lat_55_0", 0);
        chk("q_55_0",      out_quotient,  64'hFFFF_FFFF_FFFF_FFFF);
        chk("r_55_0",      out_remainder, 64'd55);
        chk("e_55_0",      {63'h0, out_error}, 64'd1);
        chk("cnt_55_0",    {56'h0, err_count}, 64'd1);
        drain("drain_55_0");

        // 1000 / 16
        accept(32'd1000, 32'd16);
        wait_valid("lat_1000_16", 2);
        chk("q_1000_16",   out_quotient,  64'd62);
        chk("r_1000_16",   out_remainder, 64'd8);
        chk("e_1000_16",   {63'h0, out_error}, 64'd0);
        chk("cnt_1000_16", {56'h0, err_count}, 64'd1);
        drain("drain_1000_16");

        // only the top divisor bit set: must not be taken as zero
        accept(32'hFFFF_FFFF, 32'h8000_0000);
        wait_valid("lat_msb", 2);
        chk("q_msb",       out_quotient,  64'd1);
        chk("r_msb",       out_remainder, 64'h7FFF_FFFF);
        chk("e_msb",       {63'h0, out_error}, 64'd0);
        chk("cnt_msb",     {56'h0, err_count}, 64'd1);
        drain("drain_msb");

        // backpressure in DONE with junk requests presented
        accept(32'd20, 32'd3);
        wait_valid("lat_20_3", 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_dividend = 32'd77 + 32'(i);
            in_divisor  = 32'd0;
            @(posedge clk);
            #1;
            chk("hold_valid", {63'h0, out_valid}, 64'd1);
            chk("hold_quot",  out_quotient,  64'd6);
            chk("hold_rem",   out_remainder, 64'd2);
            chk("hold_ready", {63'h0, in_ready}, 64'd0);
            chk("hold_div_a", {32'h0, div_dividend}, 64'd20);
        end
        chk("hold_errcnt", {56'h0, err_count}, 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rel_valid",  {63'h0, out_valid}, 64'd0);
        chk("rel_ready",  {63'h0, in_ready},  64'd1);
        chk("rel_div_a",  {32'h0, div_dividend}, 64'd20);
        chk("rel_div_b",  {32'h0, div_divisor},  64'd3);
        chk("rel_errcnt", {56'h0, err_count}, 64'd1);

        // reset while in SETTLE
        accept(32'd9, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'h0, out_valid}, 64'd0);
        chk("mid_rst_quot",  out_quotient,  64'd0);
        chk("mid_rst_rem",   out_remainder, 64'd0);
        chk("mid_rst_cnt",   {56'h0, err_count}, 64'd0);
        chk("mid_rst_div_a", {32'h0, div_dividend}, 64'd0);
        chk("mid_rst_ready", {63'h0, in_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_ready", {63'h0, in_ready},  64'd1);
        chk("mid_rel_valid", {63'h0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("mid_rel_valid2", {63'h0, out_valid}, 64'd0);

        // error counter saturation
        for (int i = 0; i < 260; i++) begin
            accept(32'(i), 32'd0);
            if (i == 253) chk("sat_254", {56'h0, err_count}, 64'd254);
            if (i == 254) chk("sat_255", {56'h0, err_count}, 64'd255);
            drain("sat_drain");
        end
        chk("sat_final",  {56'h0, err_count}, 64'd255);
        chk("sat_rem",    out_remainder, 64'd259);
        chk("sat_err",    {63'h0, out_error}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
